// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a single registered output stage.
// Optional channel locking is compiled in with `define MUX_LOCK_EN.
module rr_arb_mux #(
    parameter int NBits = 32,
    parameter int NCh   = 4,
    parameter int SelW  = $clog2(NCh)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCh-1:0]       in_valid,
    input  logic [NCh*NBits-1:0] in_data,
`ifdef MUX_LOCK_EN
    input  logic [NCh-1:0]       in_lock,
`endif
    output logic [NCh-1:0]       in_ready,
    output logic                 out_valid,
    output logic [NBits-1:0]     out_data,
    output logic [SelW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [NBits-1:0] out_data_q, out_data_d;
    logic [SelW-1:0]  out_sel_q, out_sel_d;
    logic [SelW-1:0]  ptr_q, ptr_d;
    logic [SelW-1:0]  grant_idx;
    logic             found;
    logic             can_load;
    logic             xfer;
    logic             lock_active;

`ifdef MUX_LOCK_EN
    logic lock_q, lock_d;
    assign lock_active = lock_q;
`else
    assign lock_active = 1'b0;
`endif

    assign can_load = !out_valid_q || out_ready;
    assign xfer     = !reset && found && can_load;

    // While locked only the channel that holds the lock may compete.
    always_comb begin
        int              idx;
        logic [SelW-1:0] idx_s;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_s     = '0;
        if (lock_active) begin
            found     = in_valid[out_sel_q];
            grant_idx = out_sel_q;
        end else begin
            for (int i = 0; i < NCh; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NCh) begin
                    idx = idx - NCh;
                end
                idx_s = idx[SelW-1:0];
                if (!found && in_valid[idx_s]) begin
                    found     = 1'b1;
                    grant_idx = idx_s;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(grant_idx)*NBits +: NBits];
            out_sel_d   = grant_idx;
            ptr_d       = (grant_idx == SelW'(NCh - 1)) ? '0 : grant_idx + SelW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (xfer) begin
            lock_d = in_lock[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: per-cycle comparison against a behavioural model,
// plus directed vectors with literal expectations.
module tb_rr_arb_mux;

    localparam int NBits = 32;
    localparam int NCh   = 4;
    localparam int SelW  = 2;

    logic                 clk;
    logic                 reset;
    logic [NCh-1:0]       in_valid;
    logic [NCh*NBits-1:0] in_data;
    logic [NCh-1:0]       in_ready;
    logic                 out_valid;
    logic [NBits-1:0]     out_data;
    logic [SelW-1:0]      out_sel;
    logic                 out_ready;
`ifdef MUX_LOCK_EN
    logic [NCh-1:0]       in_lock;
    assign in_lock = '0;
`endif

    int checks;
    int failures;

    // model state: what the output register must hold right now
    bit          m_known;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_sel;
    int          m_ptr;

    rr_arb_mux #(.NBits(NBits), .NCh(NCh)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
`ifdef MUX_LOCK_EN
        .in_lock  (in_lock),
`endif
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model past the coming edge.
    task automatic model_step();
        logic [3:0] exp_ready;
        bit         can_load;
        int         g;
        exp_ready = '0;
        g         = -1;
        if (m_known) begin
            check("model out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("model out_data", out_data, m_data);
            check("model out_sel", {30'd0, out_sel}, m_sel);
        end
        if (reset) begin
            check("model in_ready reset", {28'd0, in_ready}, 32'd0);
            m_known = 1;
            m_valid = 0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (m_known) begin
            can_load = !m_valid || out_ready;
            for (int i = 0; i < NCh; i++) begin
                if (g < 0 && in_valid[(m_ptr + i) % NCh]) g = (m_ptr + i) % NCh;
            end
            if (g >= 0 && can_load) exp_ready[g] = 1'b1;
            check("model in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
            if (exp_ready != 0) begin
                m_valid = 1;
                m_data  = in_data[g*NBits +: NBits];
                m_sel   = g;
                m_ptr   = (g + 1) % NCh;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int k = 0; k < NCh; k++) in_data[k*NBits +: NBits] = 32'h1000_0000 + k;
    endtask

    initial begin
        logic [31:0] exp_seq_sel [6];
        logic [31:0] sparse_sel [4];
        checks    = 0;
        failures  = 0;
        m_known   = 0;
        m_valid   = 0;
        m_data    = '0;
        m_sel     = 0;
        m_ptr     = 0;
        reset     = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        set_default_data();
        exp_seq_sel = '{0, 1, 2, 3, 0, 1};
        sparse_sel  = '{3, 1, 3, 1};

        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset out_valid", {31'd0, out_valid}, 32'd0);
            check("reset out_data", out_data, 32'd0);
            check("reset out_sel", {30'd0, out_sel}, 32'd0);
            check("reset in_ready", {28'd0, in_ready}, 32'd0);
        end

        reset = 1'b0;
        #1;
        check("first in_ready", {28'd0, in_ready}, 32'h1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("rr out_valid", {31'd0, out_valid}, 32'd1);
            check("rr out_sel", {30'd0, out_sel}, exp_seq_sel[c]);
            check("rr out_data", out_data, 32'h1000_0000 + exp_seq_sel[c]);
        end

        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("sparse out_sel", {30'd0, out_sel}, sparse_sel[c]);
        end

        in_data[0 +: NBits] = 32'hDEAD_BEEF;
        in_valid = 4'b0001;
        tick();
        check("bp load data", out_data, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        #1;
        check("bp in_ready", {28'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp hold data", out_data, 32'hDEAD_BEEF);
            check("bp hold sel", {30'd0, out_sel}, 32'd0);
            check("bp hold in_ready", {28'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        check("bp nobubble valid", {31'd0, out_valid}, 32'd1);
        check("bp nobubble data", out_data, 32'h1000_0001);

        out_ready = 1'b0;
        in_valid  = 4'hF;
        tick();
        check("stall valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check("midreset valid", {31'd0, out_valid}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after reset sel", {30'd0, out_sel}, 32'd0);
        check("after reset data", out_data, 32'hDEAD_BEEF);

        in_valid = 4'b0000;
        tick();
        check("drain valid", {31'd0, out_valid}, 32'd0);
        check("drain data hold", out_data, 32'hDEAD_BEEF);

        for (int i = 0; i < 150; i++) begin
            in_valid  = 4'((i * 7 + 3) % 16);
            out_ready = (i % 5) != 0;
            for (int k = 0; k < NCh; k++) in_data[k*NBits +: NBits] = 32'h2000_0000 + (i << 8) + k;
            tick();
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
